// File: rtl/bank_loader.sv
// Host-side burst loader: buffers a valid/ready word stream and replays it
// into the Data Bank router one word per cycle while the system is READY.
module bank_loader #(
  parameter int W     = 24,
  parameter int ADDRW = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base,
  input  logic [ADDRW:0]   len,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [W-1:0]     s_data,
  output logic             s_ready,
  input  logic             READY,
  output logic [W-1:0]     DATA_IN,
  output logic [ADDRW-1:0] DIR,
  output logic             WRITE,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ADDRW + 1;
  localparam logic [AW:0] P_ONE = (AW+1)'(1);
  localparam logic [AW:0] P_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;

  logic [W-1:0]     mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      level;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [ADDRW-1:0] base_q;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    acc_cnt;
  logic [CW-1:0]    wr_cnt;

  assign level = wptr - rptr;
  assign empty = (level == '0);
  assign full  = (level == P_FULL);

  // s_ready never looks at s_valid; full blocks push even on a pop cycle
  assign s_ready = (state == LOAD) && (acc_cnt < len_q) && !full;
  assign push    = s_valid && s_ready && !abort;
  assign pop     = (state == LOAD) && !empty && READY && !abort;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      DATA_IN <= '0;
      DIR     <= '0;
      WRITE   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      WRITE   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      WRITE <= 1'b0;
      done  <= 1'b0;
      if (push) begin
        wptr    <= wptr + P_ONE;
        acc_cnt <= acc_cnt + C_ONE;
      end
      if (pop) begin
        rptr    <= rptr + P_ONE;
        DATA_IN <= mem[rptr[AW-1:0]];
        DIR     <= base_q + wr_cnt[ADDRW-1:0];
        WRITE   <= 1'b1;
        wr_cnt  <= wr_cnt + C_ONE;
      end
      unique case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            base_q  <= base;
            len_q   <= len;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // last word's WRITE cycle is already out; close the burst
          if (wr_cnt == len_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_loader.sv
// Directed bench for bank_loader: reset, bursts, wrap, backpressure,
// abort, no-op and ignored start.
module tb_bank_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base;
  logic [5:0]  len;
  logic        abort;
  logic        s_valid;
  logic [23:0] s_data;
  logic        s_ready;
  logic        READY;
  logic [23:0] DATA_IN;
  logic [4:0]  DIR;
  logic        WRITE;
  logic        busy;
  logic        done;

  int vecs = 0;
  int errs = 0;

  int base0, blen, acc, nw, ncyc;
  int first_acc, first_wr, last_wr, done_cyc;
  logic [23:0] dbase;
  bit saw_done;

  always #5 clk = ~clk;

  bank_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .READY(READY), .DATA_IN(DATA_IN), .DIR(DIR),
    .WRITE(WRITE), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input int b, input int l, input logic [23:0] db);
    base0 = b; blen = l; dbase = db;
    acc = 0; nw = 0; ncyc = 0;
    first_acc = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
    saw_done = 0;
    base = 5'(b); len = 6'(l); start = 1'b1;
    s_data = db;
    step();
    start = 1'b0;
    s_valid = 1'b1;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // one clock of host streaming plus write-side monitoring
  task automatic cyc();
    bit took;
    took = s_valid && s_ready;
    step();
    ncyc++;
    if (took) begin
      if (first_acc < 0) first_acc = ncyc;
      acc++;
      s_data = dbase + 24'(acc);
      if (acc == blen) begin
        s_valid = 1'b0;
        chk("s_ready_after_last", 32'(s_ready), 32'd0);
      end
    end
    if (WRITE) begin
      chk("dir", 32'(DIR), 32'((base0 + nw) % 32));
      chk("data", 32'(DATA_IN), 32'(dbase + 24'(nw)));
      if (first_wr < 0) first_wr = ncyc;
      last_wr = ncyc;
      nw++;
    end
    if (done && !saw_done) begin
      saw_done = 1;
      done_cyc = ncyc;
    end
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (!saw_done && n < budget) begin
      cyc();
      n++;
    end
    chk("done_seen", 32'(saw_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_write", 32'(WRITE), 32'd0);
    chk("done_after_last_wr", 32'(done_cyc), 32'(last_wr + 1));
    step();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0; READY = 1'b1;
    step(); step();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_data", 32'(DATA_IN), 32'd0);
    chk("rst_dir", 32'(DIR), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();

    // basic burst
    begin_burst(4, 3, 24'hA00001);
    chk("basic_s_ready", 32'(s_ready), 32'd1);
    run_to_done(20);
    chk("basic_nw", 32'(nw), 32'd3);
    chk("basic_latency", 32'(first_wr - first_acc), 32'd1);
    chk("basic_consec", 32'(last_wr - first_wr), 32'd2);

    // wrap, maximum length
    begin_burst(30, 32, 24'hB00000);
    run_to_done(80);
    chk("wrap_acc", 32'(acc), 32'd32);
    chk("wrap_nw", 32'(nw), 32'd32);

    // backpressure
    READY = 1'b0;
    begin_burst(0, 8, 24'hC00010);
    repeat (6) cyc();
    chk("bp_acc", 32'(acc), 32'd4);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_nw", 32'(nw), 32'd0);
    READY = 1'b1;
    run_to_done(40);
    chk("bp_acc_total", 32'(acc), 32'd8);
    chk("bp_nw_total", 32'(nw), 32'd8);

    // abort after two writes
    begin_burst(10, 5, 24'hD00000);
    for (int i = 0; i < 20 && nw < 2; i++) cyc();
    chk("ab_nw", 32'(nw), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_write", 32'(WRITE), 32'd0);
    chk("ab_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ab_quiet", 32'({WRITE, done, busy}), 32'd0);
    end

    // zero-length start is a no-op
    base = 5'd3; len = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_s_ready", 32'(s_ready), 32'd0);
    step();
    chk("noop_write", 32'(WRITE), 32'd0);

    // start during LOAD is ignored
    begin_burst(2, 3, 24'hE00000);
    base = 5'd20; len = 6'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    run_to_done(20);
    chk("ign_nw", 32'(nw), 32'd3);

    // reset mid-burst with three words buffered
    READY = 1'b0;
    begin_burst(0, 8, 24'hF00000);
    repeat (3) cyc();
    chk("mr_acc", 32'(acc), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_outs", 32'({s_ready, WRITE, busy, done}), 32'd0);
    chk("mr_data", 32'(DATA_IN), 32'd0);
    chk("mr_dir", 32'(DIR), 32'd0);
    s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    READY = 1'b1;
    step();
    begin_burst(7, 2, 24'h123450);
    run_to_done(20);
    chk("mr_nw", 32'(nw), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
